mux_sel_arbiter: RTL and testbench

MUX_SEL_ARBITER -- requirements
Module: mux_sel_arbiter

---
 rtl/mux_sel_arbiter.sv | 119 +++++++++++
 tb/tb_mux_sel_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter for four level-sensitive sources driving the select lines of a
// downstream 4:1 mux; a grant is held until ack or until the optional timeout expires.
module mux_sel_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic req2,
  input  logic req3,
  input  logic ack,
  output logic s0,
  output logic s1,
  output logic valid,
  output logic grant0,
  output logic grant1,
  output logic grant2,
  output logic grant3,
  output logic timeout
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state_reg, state_next;
  logic [1:0]    ptr_reg, ptr_next;
  logic [1:0]    sel_reg, sel_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          timeout_reg, timeout_next;

  logic [3:0]    req_vec;
  logic [3:0]    grant_vec;
  logic [1:0]    winner;
  logic          any_req;

  assign req_vec = {req3, req2, req1, req0};

  // Scan from the farthest offset down so the nearest requester to ptr is the last write.
  always_comb begin
    winner  = ptr_reg;
    any_req = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (req_vec[ptr_reg + 2'(i)]) begin
        winner  = ptr_reg + 2'(i);
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    sel_next     = sel_reg;
    cnt_next     = cnt_reg;
    timeout_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          sel_next   = winner;
          cnt_next   = '0;
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (ack) begin
          state_next = IDLE;
          ptr_next   = sel_reg + 2'd1;
        end else if (TIMEOUT > 0) begin
          // ack has priority, so the abandon path is only reached with ack low
          if (cnt_reg == CNT_LAST) begin
            state_next   = IDLE;
            ptr_next     = sel_reg + 2'd1;
            timeout_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      ptr_reg     <= 2'd0;
      sel_reg     <= 2'd0;
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      sel_reg     <= sel_next;
      cnt_reg     <= cnt_next;
      timeout_reg <= timeout_next;
    end
  end

  assign valid   = (state_reg == GRANT);
  assign s0      = sel_reg[0];
  assign s1      = sel_reg[1];
  assign timeout = timeout_reg;

  for (genvar gi = 0; gi < 4; gi++) begin : g_grant
    assign grant_vec[gi] = valid && (sel_reg == 2'(gi));
  end

  assign grant0 = grant_vec[0];
  assign grant1 = grant_vec[1];
  assign grant2 = grant_vec[2];
  assign grant3 = grant_vec[3];

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench for mux_sel_arbiter: directed scenarios on a TIMEOUT=15 and a TIMEOUT=0 instance,
// then randomized traffic compared against a simple grant/age reference model.
module tb_mux_sel_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ack = 1'b0;
  logic [3:0] req = 4'b0000;

  logic       a_s0, a_s1, a_valid, a_to;
  logic [3:0] a_g;
  logic       b_s0, b_s1, b_valid, b_to;
  logic [3:0] b_g;

  mux_sel_arbiter #(.TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req[0]), .req1(req[1]), .req2(req[2]), .req3(req[3]),
    .ack(ack),
    .s0(a_s0), .s1(a_s1), .valid(a_valid),
    .grant0(a_g[0]), .grant1(a_g[1]), .grant2(a_g[2]), .grant3(a_g[3]),
    .timeout(a_to)
  );

  mux_sel_arbiter #(.TIMEOUT(0)) dut_nt (
    .clk(clk), .rst_n(rst_n),
    .req0(req[0]), .req1(req[1]), .req2(req[2]), .req3(req[3]),
    .ack(ack),
    .s0(b_s0), .s1(b_s1), .valid(b_valid),
    .grant0(b_g[0]), .grant1(b_g[1]), .grant2(b_g[2]), .grant3(b_g[3]),
    .timeout(b_to)
  );

  always #5 clk = ~clk;

  logic       o_valid [2];
  logic [1:0] o_sel   [2];
  logic [3:0] o_g     [2];
  logic       o_to    [2];
  assign o_valid[0] = a_valid;  assign o_valid[1] = b_valid;
  assign o_sel[0]   = {a_s1, a_s0};
  assign o_sel[1]   = {b_s1, b_s0};
  assign o_g[0]     = a_g;      assign o_g[1]     = b_g;
  assign o_to[0]    = a_to;     assign o_to[1]    = b_to;

  int tests_run = 0;
  int fails = 0;

  // Reference model: one entry per instance; m_age counts completed cycles in the current grant.
  int tout    [2] = '{15, 0};
  int m_valid [2];
  int m_sel   [2];
  int m_ptr   [2];
  int m_age   [2];
  int m_to    [2];

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 0; m_sel[d] = 0; m_ptr[d] = 0; m_age[d] = 0; m_to[d] = 0;
    end
  endfunction

  function automatic void model_step();
    for (int d = 0; d < 2; d++) begin
      if (m_valid[d] != 0) begin
        if (ack) begin
          m_valid[d] = 0; m_to[d] = 0; m_ptr[d] = (m_sel[d] + 1) % 4;
        end else if (tout[d] != 0 && m_age[d] + 1 == tout[d]) begin
          m_valid[d] = 0; m_to[d] = 1; m_ptr[d] = (m_sel[d] + 1) % 4;
        end else begin
          m_age[d] = m_age[d] + 1; m_to[d] = 0;
        end
      end else begin
        int found;
        found = 0;
        m_to[d] = 0;
        for (int k = 0; k < 4; k++) begin
          int idx;
          idx = (m_ptr[d] + k) % 4;
          if (found == 0 && req[idx]) begin
            found = 1; m_sel[d] = idx;
          end
        end
        if (found != 0) begin
          m_valid[d] = 1; m_age[d] = 0;
        end
      end
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    model_reset();
    req = 4'b1111;
    repeat (2) cycle();
    tests_run++;
    if (a_valid !== 1'b0 || {a_s1, a_s0} !== 2'b00 || a_g !== 4'b0000 || a_to !== 1'b0) begin
      fails++;
      $display("FAIL reset_a: valid=%b sel=%b grant=%b to=%b, expected all zero", a_valid, {a_s1, a_s0}, a_g, a_to);
    end
    tests_run++;
    if (b_valid !== 1'b0 || {b_s1, b_s0} !== 2'b00 || b_g !== 4'b0000 || b_to !== 1'b0) begin
      fails++;
      $display("FAIL reset_b: valid=%b sel=%b grant=%b to=%b, expected all zero", b_valid, {b_s1, b_s0}, b_g, b_to);
    end
    req = 4'b0000;
    rst_n = 1'b1;
  endtask

  task automatic test_single_req();
    req = 4'b0100;
    cycle();
    tests_run++;
    if (a_valid !== 1'b1 || {a_s1, a_s0} !== 2'b10 || a_g !== 4'b0100) begin
      fails++;
      $display("FAIL single_grant: valid=%b sel=%b grant=%b, expected 1 10 0100", a_valid, {a_s1, a_s0}, a_g);
    end
    req = 4'b0000; ack = 1'b1;
    cycle();
    ack = 1'b0;
    tests_run++;
    if (a_valid !== 1'b0 || a_g !== 4'b0000 || a_to !== 1'b0) begin
      fails++;
      $display("FAIL single_release: valid=%b grant=%b to=%b, expected 0 0000 0", a_valid, a_g, a_to);
    end
    // ptr must now be 3: with req0 and req3 pending, source 3 wins
    req = 4'b1001;
    cycle();
    tests_run++;
    if (a_valid !== 1'b1 || {a_s1, a_s0} !== 2'b11) begin
      fails++;
      $display("FAIL single_ptr3: valid=%b sel=%b, expected 1 11", a_valid, {a_s1, a_s0});
    end
    req = 4'b0000; ack = 1'b1;
    cycle();
    ack = 1'b0;
  endtask

  task automatic test_round_robin();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      cycle();
      tests_run++;
      if (a_valid !== 1'b1 || {a_s1, a_s0} !== 2'(k % 4) || a_g !== 4'(1 << (k % 4))) begin
        fails++;
        $display("FAIL rr_grant%0d: valid=%b sel=%0d grant=%b, expected 1 %0d", k, a_valid, {a_s1, a_s0}, a_g, k % 4);
      end
      ack = 1'b1;
      cycle();
      ack = 1'b0;
      tests_run++;
      if (a_valid !== 1'b0 || a_g !== 4'b0000) begin
        fails++;
        $display("FAIL rr_bubble%0d: valid=%b grant=%b, expected 0 0000", k, a_valid, a_g);
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_timeout();
    req = 4'b0010;
    cycle();
    req = 4'b0000;
    tests_run++;
    if (a_valid !== 1'b1 || {a_s1, a_s0} !== 2'b01) begin
      fails++;
      $display("FAIL to_grant: valid=%b sel=%b, expected 1 01", a_valid, {a_s1, a_s0});
    end
    for (int i = 1; i < 15; i++) begin
      cycle();
      tests_run++;
      if (a_valid !== 1'b1 || a_to !== 1'b0) begin
        fails++;
        $display("FAIL to_hold%0d: valid=%b to=%b, expected 1 0", i, a_valid, a_to);
      end
    end
    cycle();
    tests_run++;
    if (a_valid !== 1'b0 || a_to !== 1'b1) begin
      fails++;
      $display("FAIL to_pulse: valid=%b to=%b, expected 0 1", a_valid, a_to);
    end
    req = 4'b0110;
    cycle();
    tests_run++;
    if (a_to !== 1'b0 || a_valid !== 1'b1 || {a_s1, a_s0} !== 2'b10) begin
      fails++;
      $display("FAIL to_after: to=%b valid=%b sel=%b, expected 0 1 10", a_to, a_valid, {a_s1, a_s0});
    end
    req = 4'b0000; ack = 1'b1;
    cycle();
    ack = 1'b0;
  endtask

  task automatic test_ack_on_timeout_edge();
    req = 4'b1000;
    cycle();
    req = 4'b0000;
    repeat (14) cycle();
    ack = 1'b1;
    cycle();
    ack = 1'b0;
    tests_run++;
    if (a_valid !== 1'b0 || a_to !== 1'b0) begin
      fails++;
      $display("FAIL ack_edge: valid=%b to=%b, expected 0 0", a_valid, a_to);
    end
    cycle();
    tests_run++;
    if (a_to !== 1'b0) begin
      fails++;
      $display("FAIL ack_edge_next: to=%b, expected 0", a_to);
    end
  endtask

  task automatic test_hold_wrap();
    req = 4'b1000;
    cycle();
    req = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      cycle();
      tests_run++;
      if (a_valid !== 1'b1 || {a_s1, a_s0} !== 2'b11 || a_g !== 4'b1000) begin
        fails++;
        $display("FAIL hold%0d: valid=%b sel=%b grant=%b, expected 1 11 1000", i, a_valid, {a_s1, a_s0}, a_g);
      end
    end
    ack = 1'b1;
    cycle();
    ack = 1'b0;
    cycle();
    tests_run++;
    if (a_valid !== 1'b1 || {a_s1, a_s0} !== 2'b00 || a_g !== 4'b0001) begin
      fails++;
      $display("FAIL wrap: valid=%b sel=%b grant=%b, expected 1 00 0001", a_valid, {a_s1, a_s0}, a_g);
    end
    req = 4'b0000; ack = 1'b1;
    cycle();
    ack = 1'b0;
  endtask

  task automatic test_async_reset();
    req = 4'b0010;
    cycle();
    tests_run++;
    if (a_valid !== 1'b1 || {a_s1, a_s0} !== 2'b01) begin
      fails++;
      $display("FAIL ares_grant: valid=%b sel=%b, expected 1 01", a_valid, {a_s1, a_s0});
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if (a_valid !== 1'b0 || {a_s1, a_s0} !== 2'b00 || a_g !== 4'b0000 || a_to !== 1'b0) begin
      fails++;
      $display("FAIL ares_async: valid=%b sel=%b grant=%b to=%b, expected all zero", a_valid, {a_s1, a_s0}, a_g, a_to);
    end
    cycle();
    rst_n = 1'b1;
    req = 4'b1010;
    cycle();
    tests_run++;
    if (a_valid !== 1'b1 || {a_s1, a_s0} !== 2'b01 || a_g !== 4'b0010) begin
      fails++;
      $display("FAIL ares_restart: valid=%b sel=%b grant=%b, expected 1 01 0010", a_valid, {a_s1, a_s0}, a_g);
    end
    req = 4'b0000; ack = 1'b1;
    cycle();
    ack = 1'b0;
  endtask

  task automatic test_no_timeout();
    req = 4'b0100;
    cycle();
    req = 4'b0000;
    for (int i = 0; i < 40; i++) begin
      cycle();
      tests_run++;
      if (b_valid !== 1'b1 || {b_s1, b_s0} !== 2'(m_sel[1]) || b_to !== 1'b0) begin
        fails++;
        $display("FAIL nt_hold%0d: valid=%b sel=%b to=%b, expected 1 %0d 0", i, b_valid, {b_s1, b_s0}, b_to, m_sel[1]);
      end
    end
    tests_run++;
    if (a_valid !== 1'b0) begin
      fails++;
      $display("FAIL nt_other_released: valid=%b, expected 0", a_valid);
    end
    ack = 1'b1;
    cycle();
    ack = 1'b0;
    tests_run++;
    if (b_valid !== 1'b0 || b_to !== 1'b0) begin
      fails++;
      $display("FAIL nt_release: valid=%b to=%b, expected 0 0", b_valid, b_to);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      int ack_pct;
      ack_pct = (i < 300) ? 30 : 4;
      req = 4'($urandom);
      if ($urandom_range(0, 3) == 0) req = 4'b0000;
      ack = ($urandom_range(0, 99) < ack_pct);
      if ($urandom_range(0, 149) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end else begin
        rst_n = 1'b1;
      end
      cycle();
      for (int d = 0; d < 2; d++) begin
        logic [3:0] eg;
        eg = (m_valid[d] != 0) ? 4'(1 << m_sel[d]) : 4'b0000;
        tests_run++;
        if (o_valid[d] !== 1'(m_valid[d]) || o_sel[d] !== 2'(m_sel[d]) || o_g[d] !== eg || o_to[d] !== 1'(m_to[d])) begin
          fails++;
          $display("FAIL rand[%0d] inst%0d: valid=%b sel=%0d grant=%b to=%b, expected %0d %0d %b %0d",
                   i, d, o_valid[d], o_sel[d], o_g[d], o_to[d], m_valid[d], m_sel[d], eg, m_to[d]);
        end
      end
    end
    rst_n = 1'b1;
    ack = 1'b0;
    req = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single_req();
    test_round_robin();
    test_timeout();
    test_ack_on_timeout_edge();
    test_hold_wrap();
    test_async_reset();
    test_no_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
